// File: rtl/qu_pkg.sv
// Shared types for the busy-table write-port controller: preg address type and controller states.
package qu_pkg;

    localparam int unsigned DEF_PHY_RF_DEPTH = 128;
    localparam int unsigned DEF_NUM_WB       = 4;
    localparam int unsigned PREG_W           = $clog2(DEF_PHY_RF_DEPTH);

    typedef logic [PREG_W-1:0] preg_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } busy_ctrl_state_t;

endpackage

// File: rtl/busy_table_ctrl_if.sv
// Request, table write/read and lookup bundle between rename/writeback, the controller and the table.
interface busy_table_ctrl_if #(
    parameter int unsigned PHY_RF_DEPTH = 128,
    parameter int unsigned NUM_WB       = 4
);
    localparam int unsigned AW = $clog2(PHY_RF_DEPTH);

    logic                 alloc_valid;
    logic [AW-1:0]        alloc_addr;
    logic                 alloc_ready;
    logic [NUM_WB-1:0]    wb_valid;
    logic [NUM_WB*AW-1:0] wb_addr;
    logic [NUM_WB-1:0]    wb_ready;
    logic                 flush_req;
    logic                 flush_busy;
    logic                 flush_done;
    logic                 bt_wr1_en;
    logic [AW-1:0]        bt_wr1_addr;
    logic                 bt_wr1_in;
    logic                 bt_wr2_en;
    logic [AW-1:0]        bt_wr2_addr;
    logic                 bt_wr2_in;
    logic [AW-1:0]        lk1_addr;
    logic [AW-1:0]        lk2_addr;
    logic                 lk1_busy;
    logic                 lk2_busy;
    logic [AW-1:0]        bt_rd1_addr;
    logic [AW-1:0]        bt_rd2_addr;
    logic                 bt_rd1_out;
    logic                 bt_rd2_out;

    modport slave (
        input  alloc_valid, alloc_addr, wb_valid, wb_addr, flush_req,
        input  lk1_addr, lk2_addr, bt_rd1_out, bt_rd2_out,
        output alloc_ready, wb_ready, flush_busy, flush_done,
        output bt_wr1_en, bt_wr1_addr, bt_wr1_in, bt_wr2_en, bt_wr2_addr, bt_wr2_in,
        output lk1_busy, lk2_busy, bt_rd1_addr, bt_rd2_addr
    );

    modport master (
        output alloc_valid, alloc_addr, wb_valid, wb_addr, flush_req,
        output lk1_addr, lk2_addr, bt_rd1_out, bt_rd2_out,
        input  alloc_ready, wb_ready, flush_busy, flush_done,
        input  bt_wr1_en, bt_wr1_addr, bt_wr1_in, bt_wr2_en, bt_wr2_addr, bt_wr2_in,
        input  lk1_busy, lk2_busy, bt_rd1_addr, bt_rd2_addr
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter granting up to two requests per cycle; a masked request is skipped and a
// second grant is refused when it conflicts with the first.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           two,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   mask,
    input  logic [N*N-1:0] conflict,
    output logic [N-1:0]   grant,
    output logic           first_valid,
    output logic [IW-1:0]  first_idx,
    output logic           second_valid,
    output logic [IW-1:0]  second_idx
);

    logic [IW-1:0] rr_q, rr_d;
    int unsigned   idx;

    always_comb begin
        grant        = '0;
        first_valid  = 1'b0;
        first_idx    = '0;
        second_valid = 1'b0;
        second_idx   = '0;
        rr_d         = rr_q;
        idx          = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (int'(rr_q) + k) % N;
            if (en && req[idx] && !mask[idx]) begin
                if (!first_valid) begin
                    first_valid = 1'b1;
                    first_idx   = IW'(idx);
                    grant[idx]  = 1'b1;
                    rr_d        = IW'((idx + 1) % N);
                end else if (two && !second_valid && !conflict[int'(first_idx) * N + idx]) begin
                    second_valid = 1'b1;
                    second_idx   = IW'(idx);
                    grant[idx]   = 1'b1;
                    rr_d         = IW'((idx + 1) % N);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/busy_table_ctrl.sv
// Busy-table write-port scheduler: merges rename busy-set and writeback clears, sequences flush.
// Optional macro QU_BT_WAKEUP_BYPASS_EN forwards same-cycle granted clears to the lookups.
module busy_table_ctrl
    import qu_pkg::*;
#(
    parameter int unsigned PHY_RF_DEPTH = DEF_PHY_RF_DEPTH,
    parameter int unsigned NUM_WB       = DEF_NUM_WB
) (
    input  logic              clk,
    input  logic              rst,
    busy_table_ctrl_if.slave  bus
);

    localparam int unsigned AW = $clog2(PHY_RF_DEPTH);
    localparam int unsigned IW = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;

    busy_ctrl_state_t state_q, state_d;
    logic [AW-1:0]    flush_ptr_q, flush_ptr_d;
    logic             flush_done_q, flush_done_d;

    logic [AW-1:0]           wb_addr_a [NUM_WB];
    logic [NUM_WB-1:0]       wb_mask;
    logic [NUM_WB*NUM_WB-1:0] wb_conflict;
    logic [NUM_WB-1:0]       wb_grant;
    logic                    alloc_grant;
    logic                    arb_en;
    logic                    g1_valid, g2_valid;
    logic [IW-1:0]           g1_idx, g2_idx;

    assign arb_en      = (state_q == IDLE);
    assign alloc_grant = arb_en && bus.alloc_valid;

    // A clear to the preg being set this cycle would collide on the table, so hold it back.
    for (genvar i = 0; i < NUM_WB; i++) begin : g_wb
        assign wb_addr_a[i] = bus.wb_addr[i*AW +: AW];
        assign wb_mask[i]   = alloc_grant && (wb_addr_a[i] == bus.alloc_addr);
        for (genvar j = 0; j < NUM_WB; j++) begin : g_cf
            assign wb_conflict[i*NUM_WB + j] = (wb_addr_a[i] == wb_addr_a[j]);
        end
    end

    rr_arbiter #(
        .N  (NUM_WB),
        .IW (IW)
    ) u_rr_arbiter (
        .clk          (clk),
        .rst          (rst),
        .en           (arb_en),
        .two          (!alloc_grant),
        .req          (bus.wb_valid),
        .mask         (wb_mask),
        .conflict     (wb_conflict),
        .grant        (wb_grant),
        .first_valid  (g1_valid),
        .first_idx    (g1_idx),
        .second_valid (g2_valid),
        .second_idx   (g2_idx)
    );

    always_comb begin
        state_d          = state_q;
        flush_ptr_d      = flush_ptr_q;
        flush_done_d     = 1'b0;
        bus.alloc_ready  = 1'b0;
        bus.wb_ready     = '0;
        bus.flush_busy   = 1'b0;
        bus.bt_wr1_en    = 1'b0;
        bus.bt_wr1_addr  = '0;
        bus.bt_wr1_in    = 1'b0;
        bus.bt_wr2_en    = 1'b0;
        bus.bt_wr2_addr  = '0;
        bus.bt_wr2_in    = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.alloc_ready = alloc_grant;
                bus.wb_ready    = wb_grant;
                if (alloc_grant) begin
                    bus.bt_wr1_en   = 1'b1;
                    bus.bt_wr1_addr = bus.alloc_addr;
                    bus.bt_wr1_in   = 1'b1;
                    if (g1_valid) begin
                        bus.bt_wr2_en   = 1'b1;
                        bus.bt_wr2_addr = wb_addr_a[g1_idx];
                    end
                end else begin
                    if (g1_valid) begin
                        bus.bt_wr1_en   = 1'b1;
                        bus.bt_wr1_addr = wb_addr_a[g1_idx];
                    end
                    if (g2_valid) begin
                        bus.bt_wr2_en   = 1'b1;
                        bus.bt_wr2_addr = wb_addr_a[g2_idx];
                    end
                end
                if (bus.flush_req) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                bus.flush_busy  = 1'b1;
                bus.bt_wr1_en   = 1'b1;
                bus.bt_wr1_addr = flush_ptr_q;
                bus.bt_wr2_en   = 1'b1;
                bus.bt_wr2_addr = flush_ptr_q | AW'(1);
                flush_ptr_d     = flush_ptr_q + AW'(2);
                if (flush_ptr_q == AW'(PHY_RF_DEPTH - 2)) begin
                    state_d      = IDLE;
                    flush_ptr_d  = '0;
                    flush_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.flush_done  = flush_done_q;
    assign bus.bt_rd1_addr = bus.lk1_addr;
    assign bus.bt_rd2_addr = bus.lk2_addr;

`ifdef QU_BT_WAKEUP_BYPASS_EN
    logic [NUM_WB-1:0] lk1_hit, lk2_hit;
    for (genvar i = 0; i < NUM_WB; i++) begin : g_byp
        assign lk1_hit[i] = wb_grant[i] && (wb_addr_a[i] == bus.lk1_addr);
        assign lk2_hit[i] = wb_grant[i] && (wb_addr_a[i] == bus.lk2_addr);
    end
    assign bus.lk1_busy = arb_en && bus.bt_rd1_out && !(|lk1_hit);
    assign bus.lk2_busy = arb_en && bus.bt_rd2_out && !(|lk2_hit);
`else
    assign bus.lk1_busy = arb_en && bus.bt_rd1_out;
    assign bus.lk2_busy = arb_en && bus.bt_rd2_out;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            flush_ptr_q  <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_ptr_q  <= flush_ptr_d;
            flush_done_q <= flush_done_d;
        end
    end

endmodule

// File: tb/tb_busy_table_ctrl.sv
// Directed bench for busy_table_ctrl with a behavioural 128-entry busy table behind the write ports.
module tb_busy_table_ctrl;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    busy_table_ctrl_if #(.PHY_RF_DEPTH(128), .NUM_WB(4)) bus ();

    busy_table_ctrl #(
        .PHY_RF_DEPTH (128),
        .NUM_WB       (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic bt_mem [128];
    logic fill_req;
    logic fill_val;

    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < 128; i++) bt_mem[i] <= fill_val;
        end else begin
            if (bus.bt_wr1_en) bt_mem[bus.bt_wr1_addr] <= bus.bt_wr1_in;
            if (bus.bt_wr2_en) bt_mem[bus.bt_wr2_addr] <= bus.bt_wr2_in;
        end
    end

    assign bus.bt_rd1_out = bt_mem[bus.bt_rd1_addr];
    assign bus.bt_rd2_out = bt_mem[bus.bt_rd2_addr];

    logic [24:0] obs;
    assign obs = {bus.alloc_ready, bus.wb_ready, bus.bt_wr1_en, bus.bt_wr1_addr, bus.bt_wr1_in,
                  bus.bt_wr2_en, bus.bt_wr2_addr, bus.bt_wr2_in, bus.flush_busy, bus.flush_done};

    function automatic logic [24:0] ev(input logic ar, input logic [3:0] wr, input logic e1,
                                       input int a1, input logic i1, input logic e2, input int a2,
                                       input logic i2, input logic fb, input logic fd);
        return {ar, wr, e1, a1[6:0], i1, e2, a2[6:0], i2, fb, fd};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic v);
        fill_val = v;
        fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
    endtask

    task automatic test_reset();
        logic [24:0] e;
        rst = 1'b0;
        #1;
        e = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        if (obs !== e) begin
            miscompares++;
            $display("FAIL reset_hold obs=%h exp=%h", obs, e);
        end
        vectors++;
        tick();
        tick();
        rst = 1'b1;
        #1;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL reset_release obs=%h exp=%h", obs, e);
        end
        vectors++;
        fill(1'b0);
    endtask

    task automatic test_alloc();
        logic [24:0] e;
        bus.alloc_valid = 1'b1;
        bus.alloc_addr  = 7'd5;
        #1;
        e = ev(1, 0, 1, 5, 1, 0, 0, 0, 0, 0);
        if (obs !== e) begin
            miscompares++;
            $display("FAIL alloc_set obs=%h exp=%h", obs, e);
        end
        vectors++;
        tick();
        bus.alloc_valid = 1'b0;
        bus.lk1_addr    = 7'd5;
        #1;
        if ({bus.lk1_busy, bus.bt_rd1_addr} !== {1'b1, 7'd5}) begin
            miscompares++;
            $display("FAIL alloc_lookup obs=%b/%0d exp=1/5", bus.lk1_busy, bus.bt_rd1_addr);
        end
        vectors++;
    endtask

    task automatic test_wb_rr();
        logic [24:0] e;
        fill(1'b1);
        bus.wb_addr  = {7'd13, 7'd12, 7'd11, 7'd10};
        bus.wb_valid = 4'b1111;
        #1;
        e = ev(0, 4'b0011, 1, 10, 0, 1, 11, 0, 0, 0);
        if (obs !== e) begin
            miscompares++;
            $display("FAIL wb_rr_c0 obs=%h exp=%h", obs, e);
        end
        vectors++;
        tick();
        bus.wb_valid = 4'b1100;
        #1;
        e = ev(0, 4'b1100, 1, 12, 0, 1, 13, 0, 0, 0);
        if (obs !== e) begin
            miscompares++;
            $display("FAIL wb_rr_c1 obs=%h exp=%h", obs, e);
        end
        vectors++;
        tick();
        bus.wb_valid = 4'b0000;
        bus.lk1_addr = 7'd10;
        bus.lk2_addr = 7'd13;
        #1;
        if ({bus.lk1_busy, bus.lk2_busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL wb_rr_clear_a obs=%b exp=00", {bus.lk1_busy, bus.lk2_busy});
        end
        vectors++;
        bus.lk1_addr = 7'd11;
        bus.lk2_addr = 7'd14;
        #1;
        if ({bus.lk1_busy, bus.lk2_busy} !== 2'b01) begin
            miscompares++;
            $display("FAIL wb_rr_clear_b obs=%b exp=01", {bus.lk1_busy, bus.lk2_busy});
        end
        vectors++;
    endtask

    task automatic test_conflict();
        logic [24:0] e;
        bus.alloc_valid = 1'b1;
        bus.alloc_addr  = 7'd20;
        bus.wb_addr     = {7'd0, 7'd0, 7'd21, 7'd20};
        bus.wb_valid    = 4'b0011;
        #1;
        e = ev(1, 4'b0010, 1, 20, 1, 1, 21, 0, 0, 0);
        if (obs !== e) begin
            miscompares++;
            $display("FAIL conflict_c0 obs=%h exp=%h", obs, e);
        end
        vectors++;
        tick();
        bus.alloc_valid = 1'b0;
        bus.wb_valid    = 4'b0001;
        #1;
        e = ev(0, 4'b0001, 1, 20, 0, 0, 0, 0, 0, 0);
        if (obs !== e) begin
            miscompares++;
            $display("FAIL conflict_c1 obs=%h exp=%h", obs, e);
        end
        vectors++;
        tick();
        bus.wb_valid = 4'b0000;
    endtask

    task automatic test_same_addr();
        logic [24:0] e;
        bus.wb_addr  = {7'd30, 7'd30, 7'd0, 7'd0};
        bus.wb_valid = 4'b1100;
        #1;
        e = ev(0, 4'b0100, 1, 30, 0, 0, 0, 0, 0, 0);
        if (obs !== e) begin
            miscompares++;
            $display("FAIL same_addr_c0 obs=%h exp=%h", obs, e);
        end
        vectors++;
        tick();
        bus.wb_valid = 4'b1000;
        #1;
        e = ev(0, 4'b1000, 1, 30, 0, 0, 0, 0, 0, 0);
        if (obs !== e) begin
            miscompares++;
            $display("FAIL same_addr_c1 obs=%h exp=%h", obs, e);
        end
        vectors++;
        tick();
        bus.wb_valid = 4'b0000;
    endtask

    task automatic test_bypass();
        logic exp_now;
`ifdef QU_BT_WAKEUP_BYPASS_EN
        exp_now = 1'b0;
`else
        exp_now = 1'b1;
`endif
        bus.lk1_addr = 7'd7;
        #1;
        if (bus.lk1_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL bypass_pre obs=%b exp=1", bus.lk1_busy);
        end
        vectors++;
        bus.wb_addr  = {7'd0, 7'd0, 7'd0, 7'd7};
        bus.wb_valid = 4'b0001;
        #1;
        if ({bus.wb_ready[0], bus.lk1_busy} !== {1'b1, exp_now}) begin
            miscompares++;
            $display("FAIL bypass_same obs=%b%b exp=1%b", bus.wb_ready[0], bus.lk1_busy, exp_now);
        end
        vectors++;
        tick();
        bus.wb_valid = 4'b0000;
        #1;
        if (bus.lk1_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bypass_next obs=%b exp=0", bus.lk1_busy);
        end
        vectors++;
    endtask

    task automatic test_flush();
        logic [24:0] e;
        fill(1'b1);
        bus.flush_req   = 1'b1;
        bus.alloc_valid = 1'b1;
        bus.alloc_addr  = 7'd40;
        #1;
        e = ev(1, 0, 1, 40, 1, 0, 0, 0, 0, 0);
        if (obs !== e) begin
            miscompares++;
            $display("FAIL flush_entry obs=%h exp=%h", obs, e);
        end
        vectors++;
        tick();
        bus.alloc_valid = 1'b0;
        bus.wb_addr     = {7'd0, 7'd0, 7'd0, 7'd50};
        bus.wb_valid    = 4'b0001;
        bus.lk1_addr    = 7'd100;
        bus.lk2_addr    = 7'd101;
        for (int c = 0; c < 64; c++) begin
            bus.flush_req = (c == 5);
            #1;
            e = ev(0, 0, 1, 2 * c, 0, 1, 2 * c + 1, 0, 1, 0);
            if ({obs, bus.lk1_busy, bus.lk2_busy} !== {e, 2'b00}) begin
                miscompares++;
                $display("FAIL flush_cycle%0d obs=%h/%b%b exp=%h/00", c, obs, bus.lk1_busy,
                         bus.lk2_busy, e);
            end
            vectors++;
            tick();
        end
        bus.flush_req = 1'b0;
        #1;
        e = ev(0, 4'b0001, 1, 50, 0, 0, 0, 0, 0, 1);
        if (obs !== e) begin
            miscompares++;
            $display("FAIL flush_done obs=%h exp=%h", obs, e);
        end
        vectors++;
        tick();
        bus.wb_valid = 4'b0000;
        #1;
        e = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        if (obs !== e) begin
            miscompares++;
            $display("FAIL flush_after obs=%h exp=%h", obs, e);
        end
        vectors++;
        for (int a = 0; a < 64; a++) begin
            bus.lk1_addr = 7'(2 * a);
            bus.lk2_addr = 7'(2 * a + 1);
            #1;
            if ({bus.lk1_busy, bus.lk2_busy} !== 2'b00) begin
                miscompares++;
                $display("FAIL flush_sweep%0d obs=%b%b exp=00", a, bus.lk1_busy, bus.lk2_busy);
            end
            vectors++;
        end
    endtask

    task automatic test_flush_reset();
        logic [24:0] e;
        fill(1'b1);
        bus.flush_req = 1'b1;
        #1;
        tick();
        bus.flush_req = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        #1;
        e = ev(0, 0, 1, 20, 0, 1, 21, 0, 1, 0);
        if (obs !== e) begin
            miscompares++;
            $display("FAIL abort_pre obs=%h exp=%h", obs, e);
        end
        vectors++;
        rst = 1'b0;
        #1;
        e = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        if (obs !== e) begin
            miscompares++;
            $display("FAIL abort_hold obs=%h exp=%h", obs, e);
        end
        vectors++;
        tick();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL abort_idle%0d obs=%h exp=%h", c, obs, e);
            end
            vectors++;
            tick();
        end
        bus.lk1_addr = 7'd30;
        bus.lk2_addr = 7'd5;
        #1;
        if ({bus.lk1_busy, bus.lk2_busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL abort_partial obs=%b%b exp=10", bus.lk1_busy, bus.lk2_busy);
        end
        vectors++;
        bus.flush_req = 1'b1;
        #1;
        tick();
        bus.flush_req = 1'b0;
        #1;
        e = ev(0, 0, 1, 0, 0, 1, 1, 0, 1, 0);
        if (obs !== e) begin
            miscompares++;
            $display("FAIL abort_reflush obs=%h exp=%h", obs, e);
        end
        vectors++;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        fill_req        = 1'b0;
        fill_val        = 1'b0;
        bus.alloc_valid = 1'b0;
        bus.alloc_addr  = '0;
        bus.wb_valid    = '0;
        bus.wb_addr     = '0;
        bus.flush_req   = 1'b0;
        bus.lk1_addr    = '0;
        bus.lk2_addr    = '0;
        test_reset();
        test_alloc();
        test_wb_rr();
        test_conflict();
        test_same_addr();
        test_bypass();
        test_flush();
        test_flush_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
